// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU MEM stage and a DMA loader.
// Optional ARB_STATS_EN adds saturating stall_cycles / dma_beats counters.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] dma_beats
`endif
);

  typedef enum logic [0:0] {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT - 1);
  localparam logic [7:0] BEAT_LIM = 8'(BURST_LEN - 1);

  owner_e     owner_q, owner_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       cpu_req;
  logic       dma_sel;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  assign cpu_req = cpu_rd | cpu_wr;

  // State register: ownership and the starvation/burst counters
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      owner_q    <= OWN_CPU;
      wait_cnt_q <= 8'd0;
      beat_cnt_q <= 8'd0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic: CPU priority, bounded DMA wait and bounded DMA burst
  always_comb begin
    owner_d    = owner_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    case (owner_q)
      OWN_CPU: begin
        if (dma_req) begin
          if (!cpu_req || (wait_cnt_q >= WAIT_LIM)) begin
            owner_d    = OWN_DMA;
            wait_cnt_d = 8'd0;
            beat_cnt_d = 8'd0;
          end else begin
            wait_cnt_d = sat_inc8(wait_cnt_q);
          end
        end else begin
          wait_cnt_d = 8'd0;
        end
      end
      OWN_DMA: begin
        // A dropped request hands back in the same cycle, so the CPU never sees a bubble
        if (!dma_req || (beat_cnt_q == BEAT_LIM)) begin
          owner_d    = OWN_CPU;
          wait_cnt_d = 8'd0;
          beat_cnt_d = 8'd0;
        end else begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: begin
        owner_d    = OWN_CPU;
        wait_cnt_d = 8'd0;
        beat_cnt_d = 8'd0;
      end
    endcase
  end

  // Output logic: zero-latency bus mux toward DataMem
  always_comb begin
    dma_sel = (owner_q == OWN_DMA) && dma_req;
    if (dma_sel) begin
      mem_rd    = !dma_we;
      mem_wr    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else begin
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
    dma_ack   = dma_sel;
    cpu_stall = cpu_req && dma_sel;
    cpu_rdata = mem_rdata;
    dma_rdata = mem_rdata;
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] dma_beats_q, dma_beats_d;

  // Statistics registers
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      stall_cycles_q <= 16'd0;
      dma_beats_q    <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      dma_beats_q    <= dma_beats_d;
    end
  end

  // Statistics next-state: saturating event counters
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    dma_beats_d    = dma_beats_q;
    if (cpu_stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (dma_ack && (dma_beats_q != 16'hFFFF)) begin
      dma_beats_d = dma_beats_q + 16'd1;
    end else begin
      dma_beats_d = dma_beats_q;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign dma_beats    = dma_beats_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-cycle expected bus state queued at drive time,
// popped and compared on the falling edge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        cpu_rd, cpu_wr, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_ack, mem_rd, mem_wr;
`ifdef ARB_STATS_EN
  logic [15:0] stall_cycles, dma_beats;
`endif

  logic [31:0] mem_arr [0:63];

  typedef struct {
    string        name;
    logic [67:0]  v;   // {ack, stall, rd, wr, addr, wdata}
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4), .BURST_LEN(4)) dut (
    .clk(clk), .reset_b(reset_b),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stall_cycles(stall_cycles), .dma_beats(dma_beats)
`endif
  );

  assign mem_rdata = mem_arr[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_wr) mem_arr[mem_addr[7:2]] <= mem_wdata;
  end

  // Scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    logic [67:0] got;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got = {dma_ack, cpu_stall, mem_rd, mem_wr, mem_addr, mem_wdata};
      n_checks++;
      if (got !== e.v)
        $display("FAIL %s: observed ack/stall/rd/wr/addr/wdata=%h expected %h", e.name, got, e.v);
      else
        n_pass++;
    end
  end

  task automatic step(input string name, input logic c_rd, input logic [31:0] c_addr,
                      input logic d_req, input logic d_we, input logic [31:0] d_addr,
                      input logic [31:0] d_wdata, input logic e_ack);
    exp_t e;
    @(posedge clk); #1;
    cpu_rd = c_rd; cpu_wr = 1'b0; cpu_addr = c_addr; cpu_wdata = 32'h0;
    dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wdata;
    e.name = name;
    if (e_ack) e.v = {1'b1, c_rd, !d_we, d_we, d_addr, d_wdata};
    else       e.v = {1'b0, 1'b0, c_rd, 1'b0, c_addr, 32'h0};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'hF0; dma_wdata = 32'h1;
    #2;
    n_checks++;
    if ({mem_rd, mem_wr, mem_addr, dma_ack, cpu_stall} !== {1'b1, 1'b0, 32'h10, 1'b0, 1'b0})
      $display("FAIL reset_mux: observed rd=%b wr=%b addr=%h ack=%b stall=%b expected rd=1 wr=0 addr=10 ack=0 stall=0",
               mem_rd, mem_wr, mem_addr, dma_ack, cpu_stall);
    else n_pass++;
`ifdef ARB_STATS_EN
    n_checks++;
    if ({stall_cycles, dma_beats} !== 32'h0)
      $display("FAIL reset_stats: observed %h/%h expected 0/0", stall_cycles, dma_beats);
    else n_pass++;
`endif
    cpu_rd = 1'b0; dma_req = 1'b0;
    #6 reset_b = 1'b1;
  endtask

  task automatic test_dma_only();
    logic exp_ack [0:8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int k = 0;
    for (int i = 0; i < 9; i++) begin
      step($sformatf("dma_only_c%0d", i), 1'b0, 32'h0, (k < 6), 1'b1,
           32'h80 + 32'(4 * k), 32'hA5A5_0000 + 32'(k), exp_ack[i]);
      if (exp_ack[i]) k++;
    end
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (mem_arr[32 + j] !== 32'hA5A5_0000 + 32'(j))
        $display("FAIL dma_write_%0d: observed %h expected %h", j, mem_arr[32 + j], 32'hA5A5_0000 + 32'(j));
      else n_pass++;
    end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 16; i++) begin
      step($sformatf("contend_c%0d", i), 1'b1, 32'h20, 1'b1, 1'b1, 32'hC0, 32'h5555_0000,
           ((i % 8) >= 4));
    end
  endtask

  task automatic test_dma_drop();
    logic req [0:9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic ack [0:9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step($sformatf("drop_c%0d", i), (i == 3), 32'h24, req[i], 1'b1, 32'hC4,
           32'h6666_0000 + 32'(i), ack[i]);
    end
  endtask

  task automatic test_dma_read();
    step("read_sw", 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    step("read_beat", 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({dma_ack, dma_rdata, cpu_rdata, mem_wr} !== {1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0})
      $display("FAIL dma_read: observed ack=%b rdata=%h cpu_rdata=%h wr=%b expected ack=1 rdata=deadbeef wr=0",
               dma_ack, dma_rdata, cpu_rdata, mem_wr);
    else n_pass++;
    step("read_ret", 1'b0, 32'h0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
    @(negedge clk);
`ifdef ARB_STATS_EN
    n_checks++;
    if ({stall_cycles, dma_beats} !== {16'd8, 16'd21})
      $display("FAIL stats_count: observed stall=%0d beats=%0d expected 8/21", stall_cycles, dma_beats);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_burst();
    step("mid_sw", 1'b0, 32'h0, 1'b1, 1'b1, 32'hC8, 32'h11, 1'b0);
    step("mid_b1", 1'b0, 32'h0, 1'b1, 1'b1, 32'hC8, 32'h11, 1'b1);
    step("mid_b2", 1'b0, 32'h0, 1'b1, 1'b1, 32'hC8, 32'h11, 1'b1);
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_addr = 32'h28;
    #1 reset_b = 1'b0;
    #1;
    n_checks++;
    if ({dma_ack, cpu_stall, mem_rd, mem_wr, mem_addr} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h28})
      $display("FAIL mid_reset: observed ack=%b stall=%b rd=%b wr=%b addr=%h expected ack=0 stall=0 rd=1 wr=0 addr=28",
               dma_ack, cpu_stall, mem_rd, mem_wr, mem_addr);
    else n_pass++;
`ifdef ARB_STATS_EN
    n_checks++;
    if ({stall_cycles, dma_beats} !== 32'h0)
      $display("FAIL mid_reset_stats: observed %h/%h expected 0/0", stall_cycles, dma_beats);
    else n_pass++;
`endif
    #1 reset_b = 1'b1;
    step("post_reset_cpu", 1'b1, 32'h2C, 1'b1, 1'b1, 32'hC8, 32'h11, 1'b0);
    step("post_reset_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
    mem_arr[16] = 32'hDEADBEEF;
    test_reset();
    test_dma_only();
    test_contention();
    test_dma_drop();
    test_dma_read();
    test_reset_mid_burst();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
